// File: rtl/spart_pkg.sv
// -----------------------------------------------------------------------------
// spart_pkg
// Shared definitions for the spart bus-master driver:
//   - spart register addresses (ioaddr encodings)
//   - driver FSM state type
//   - baud_divisor(): rounded 16-bit divisor for a DIP baud selection
// No ports (package).
// -----------------------------------------------------------------------------
package spart_pkg;

  localparam logic [1:0] IOADDR_RXTX   = 2'b00;
  localparam logic [1:0] IOADDR_STATUS = 2'b01;
  localparam logic [1:0] IOADDR_DBLO   = 2'b10;
  localparam logic [1:0] IOADDR_DBHI   = 2'b11;

  typedef enum logic [2:0] {
    CFG_LO   = 3'd0,
    CFG_GAP  = 3'd1,
    CFG_HI   = 3'd2,
    IDLE     = 3'd3,
    RD       = 3'd4,
    WAIT_TBR = 3'd5,
    WR       = 3'd6
  } state_t;

  // divisor = round(clk_hz / baud) - 1, truncated to 16 bits.
  function automatic logic [15:0] baud_divisor(input longint unsigned clk_hz,
                                               input logic [1:0]      br_cfg);
    longint unsigned baud;
    longint unsigned div;
    case (br_cfg)
      2'b00:   baud = 64'd4800;
      2'b01:   baud = 64'd9600;
      2'b10:   baud = 64'd19200;
      2'b11:   baud = 64'd38400;
      default: baud = 64'd9600;
    endcase
    div = (clk_hz + baud / 64'd2) / baud - 64'd1;
    return div[15:0];
  endfunction

endpackage

// File: rtl/spart_driver_if.sv
// -----------------------------------------------------------------------------
// spart_driver_if
// Control side of the processor <-> spart bus.
//   iocs   : chip select (one-cycle accesses)
//   iorw   : 1 = read, 0 = write
//   ioaddr : register address
//   rda    : receive data available (from spart, may be a 1-cycle pulse)
//   tbr    : transmit buffer ready (from spart, level)
// The 8-bit data bus is a tri-state net and stays a plain inout port on the
// driver so the resolution stays visible at board top level.
// -----------------------------------------------------------------------------
interface spart_driver_if;
  logic       iocs;
  logic       iorw;
  logic [1:0] ioaddr;
  logic       rda;
  logic       tbr;

  modport master (
    output iocs,
    output iorw,
    output ioaddr,
    input  rda,
    input  tbr
  );

  modport slave (
    input  iocs,
    input  iorw,
    input  ioaddr,
    output rda,
    output tbr
  );
endinterface

// File: rtl/spart_driver_sync2.sv
// -----------------------------------------------------------------------------
// sync2
// Two-flop synchroniser for a slow asynchronous bus (e.g. DIP switches).
//   clk : destination clock
//   d_i : asynchronous input, WIDTH bits
//   q_o : synchronised output, two clk edges of latency
// The flops carry no reset: they keep sampling while the system is held in
// reset, so the value is already settled when the driver first programs the
// divisor after reset release.
// -----------------------------------------------------------------------------
module sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    meta_q <= d_i;
    sync_q <= meta_q;
  end

  assign q_o = sync_q;

endmodule

// File: rtl/spart_driver.sv
// -----------------------------------------------------------------------------
// spart_driver
// Processor-side bus master for spart. After reset it programs the baud
// divisor chosen by br_cfg, then echoes every received byte back to spart.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   br_cfg    : DIP baud select (asynchronous)
//   bus       : spart_driver_if.master (iocs/iorw/ioaddr out, rda/tbr in)
//   databus   : 8-bit tri-state data bus, driven only during writes
//   echo_byte : last byte read from spart
//   overrun   : sticky, a new byte arrived while one was awaiting transmit
// Bus outputs are registered from the current state, so each bus access is
// visible the cycle after the FSM sits in the matching access state; every
// access state is followed by a non-access state, which keeps accesses from
// ever running back to back.
// -----------------------------------------------------------------------------
module spart_driver
  import spart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 32'd50_000_000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [1:0]     br_cfg,
  spart_driver_if.master bus,
  inout  wire  [7:0]     databus,
  output logic [7:0]     echo_byte,
  output logic           overrun
);

  localparam logic [15:0] DIV_TABLE [4] = '{
    baud_divisor(64'(CLK_HZ), 2'b00),
    baud_divisor(64'(CLK_HZ), 2'b01),
    baud_divisor(64'(CLK_HZ), 2'b10),
    baud_divisor(64'(CLK_HZ), 2'b11)
  };

  logic [1:0]  cfg_sync_s;

  state_t      state_q,    state_d;
  logic        iocs_q,     iocs_d;
  logic        iorw_q,     iorw_d;
  logic [1:0]  ioaddr_q,   ioaddr_d;
  logic        drive_q,    drive_d;
  logic [7:0]  wdata_q,    wdata_d;
  logic [15:0] div_q,      div_d;
  logic [1:0]  cfg_prog_q, cfg_prog_d;
  logic        rda_pend_q, rda_pend_d;
  logic [7:0]  echo_q,     echo_d;
  logic        overrun_q,  overrun_d;

  sync2 #(.WIDTH(2)) u_cfg_sync (
    .clk (clk),
    .d_i (br_cfg),
    .q_o (cfg_sync_s)
  );

  // Next state, next bus outputs and flag updates.
  always_comb begin
    state_d    = state_q;
    iocs_d     = 1'b0;
    iorw_d     = 1'b1;
    ioaddr_d   = IOADDR_RXTX;
    drive_d    = 1'b0;
    wdata_d    = wdata_q;
    div_d      = div_q;
    cfg_prog_d = cfg_prog_q;

    // A new rda beats the clear issued in RD.
    rda_pend_d = bus.rda | (rda_pend_q & (state_q != RD));

    // The pend flag is already occupied from RD until the echo write.
    overrun_d  = overrun_q | (bus.rda & ((state_q == WAIT_TBR) || (state_q == WR)));

    // The read access is on the bus now; take the byte at the end of it.
    if (iocs_q && iorw_q) begin
      echo_d = databus;
    end else begin
      echo_d = echo_q;
    end

    case (state_q)
      CFG_LO: begin
        div_d      = DIV_TABLE[cfg_sync_s];
        cfg_prog_d = cfg_sync_s;
        iocs_d     = 1'b1;
        iorw_d     = 1'b0;
        ioaddr_d   = IOADDR_DBLO;
        drive_d    = 1'b1;
        wdata_d    = div_d[7:0];
        state_d    = CFG_GAP;
      end
      CFG_GAP: begin
        state_d = CFG_HI;
      end
      CFG_HI: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = IOADDR_DBHI;
        drive_d  = 1'b1;
        wdata_d  = div_q[15:8];
        state_d  = IDLE;
      end
      IDLE: begin
        // Reconfiguration has priority; a pending byte stays pending.
        if (cfg_sync_s != cfg_prog_q) begin
          state_d = CFG_LO;
        end else if (rda_pend_q) begin
          state_d = RD;
        end else begin
          state_d = IDLE;
        end
      end
      RD: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b1;
        ioaddr_d = IOADDR_RXTX;
        state_d  = WAIT_TBR;
      end
      WAIT_TBR: begin
        // First tbr sample here is already three cycles past any earlier write.
        if (bus.tbr) begin
          state_d = WR;
        end else begin
          state_d = WAIT_TBR;
        end
      end
      WR: begin
        iocs_d   = 1'b1;
        iorw_d   = 1'b0;
        ioaddr_d = IOADDR_RXTX;
        drive_d  = 1'b1;
        wdata_d  = echo_q;
        state_d  = IDLE;
      end
      default: begin
        state_d = CFG_LO;
      end
    endcase
  end

  // State and output registers; reset aborts any access and releases the bus.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= CFG_LO;
      iocs_q     <= 1'b0;
      iorw_q     <= 1'b1;
      ioaddr_q   <= IOADDR_RXTX;
      drive_q    <= 1'b0;
      wdata_q    <= 8'h00;
      div_q      <= 16'h0000;
      cfg_prog_q <= 2'b00;
      rda_pend_q <= 1'b0;
      echo_q     <= 8'h00;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      iocs_q     <= iocs_d;
      iorw_q     <= iorw_d;
      ioaddr_q   <= ioaddr_d;
      drive_q    <= drive_d;
      wdata_q    <= wdata_d;
      div_q      <= div_d;
      cfg_prog_q <= cfg_prog_d;
      rda_pend_q <= rda_pend_d;
      echo_q     <= echo_d;
      overrun_q  <= overrun_d;
    end
  end

  assign bus.iocs   = iocs_q;
  assign bus.iorw   = iorw_q;
  assign bus.ioaddr = ioaddr_q;
  assign databus    = drive_q ? wdata_q : 8'hzz;
  assign echo_byte  = echo_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_spart_driver.sv
// -----------------------------------------------------------------------------
// tb_spart_driver
// Directed bench for spart_driver. Expected bus accesses are queued as the
// stimulus is applied and checked by a negedge monitor as the DUT performs
// them. A spart model returns read data during reads and otherwise drives a
// background pattern whenever the DUT is not writing.
// -----------------------------------------------------------------------------
module tb_spart_driver;
  import spart_pkg::*;

  typedef struct packed {
    logic       iorw;
    logic [1:0] ioaddr;
    logic [7:0] data;
  } txn_t;

  localparam logic [7:0] BG_DATA = 8'hC3;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] br_cfg;
  wire  [7:0] databus;
  logic [7:0] echo_byte;
  logic       overrun;
  logic [7:0] spart_rd_data;
  logic       prev_iocs = 1'b0;

  int   vectors     = 0;
  int   miscompares = 0;
  txn_t exp_q[$];

  spart_driver_if bus_if ();

  spart_driver #(.CLK_HZ(32'd50_000_000)) dut (
    .clk       (clk),
    .rst       (rst),
    .br_cfg    (br_cfg),
    .bus       (bus_if),
    .databus   (databus),
    .echo_byte (echo_byte),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  // spart model: hands read data during reads, background pattern otherwise.
  assign databus = (bus_if.iocs && !bus_if.iorw) ? 8'hzz :
                   (bus_if.iocs ? spart_rd_data : BG_DATA);

  function automatic txn_t mk(input logic iorw, input logic [1:0] addr, input logic [7:0] data);
    txn_t t;
    t.iorw   = iorw;
    t.ioaddr = addr;
    t.data   = data;
    return t;
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Bus monitor: every access must match the head of the expectation queue.
  always @(negedge clk) begin
    if (bus_if.iocs === 1'b1) begin
      check8("no_back_to_back", {7'd0, prev_iocs}, 8'h00);
      vectors++;
      assert (exp_q.size() != 0) else begin
        miscompares++;
        $error("FAIL unexpected_access observed iorw=%b ioaddr=%b data=%h expected none",
               bus_if.iorw, bus_if.ioaddr, databus);
      end
      if (exp_q.size() != 0) begin
        txn_t e;
        e = exp_q.pop_front();
        check8("acc_iorw",   {7'd0, bus_if.iorw}, {7'd0, e.iorw});
        check8("acc_ioaddr", {6'd0, bus_if.ioaddr}, {6'd0, e.ioaddr});
        check8("acc_data",   databus, e.data);
      end
    end
    prev_iocs = bus_if.iocs;
  end

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    vectors++;
    assert (exp_q.size() == 0) else begin
      miscompares++;
      $error("FAIL %s observed pending=%0d expected pending=0", tag, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic pulse_rda();
    @(posedge clk);
    #2 bus_if.rda = 1'b1;
    @(posedge clk);
    #2 bus_if.rda = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    br_cfg        = 2'b01;
    bus_if.rda    = 1'b0;
    bus_if.tbr    = 1'b0;
    spart_rd_data = 8'h00;

    // Reset state
    idle_cycles(4);
    @(negedge clk);
    check8("rst_iocs",    {7'd0, bus_if.iocs}, 8'h00);
    check8("rst_iorw",    {7'd0, bus_if.iorw}, 8'h01);
    check8("rst_ioaddr",  {6'd0, bus_if.ioaddr}, 8'h00);
    check8("rst_databus", databus, BG_DATA);
    check8("rst_echo",    echo_byte, 8'h00);
    check8("rst_overrun", {7'd0, overrun}, 8'h00);

    // 9600 baud divisor 0x1457 programmed once
    exp_q.push_back(mk(1'b0, IOADDR_DBLO, 8'h57));
    exp_q.push_back(mk(1'b0, IOADDR_DBHI, 8'h14));
    @(posedge clk);
    #2 rst = 1'b0;
    drain("cfg_9600", 20);
    idle_cycles(10);

    // Echo of 0xA5 with latency checks
    bus_if.tbr    = 1'b1;
    spart_rd_data = 8'hA5;
    exp_q.push_back(mk(1'b1, IOADDR_RXTX, 8'hA5));
    exp_q.push_back(mk(1'b0, IOADDR_RXTX, 8'hA5));
    pulse_rda();
    @(negedge clk);
    check8("lat_n0_iocs", {7'd0, bus_if.iocs}, 8'h00);
    @(negedge clk);
    check8("lat_n1_iocs", {7'd0, bus_if.iocs}, 8'h00);
    @(negedge clk);
    check8("lat_rd_iocs", {7'd0, bus_if.iocs}, 8'h01);
    check8("lat_rd_iorw", {7'd0, bus_if.iorw}, 8'h01);
    @(negedge clk);
    check8("lat_gap_iocs", {7'd0, bus_if.iocs}, 8'h00);
    @(negedge clk);
    check8("lat_wr_iocs", {7'd0, bus_if.iocs}, 8'h01);
    check8("lat_wr_iorw", {7'd0, bus_if.iorw}, 8'h00);
    drain("echo_a5", 20);
    check8("echo_a5", echo_byte, 8'hA5);
    check8("overrun_clear", {7'd0, overrun}, 8'h00);

    // tbr held low: second byte overruns, no write until tbr returns
    bus_if.tbr    = 1'b0;
    spart_rd_data = 8'h3C;
    exp_q.push_back(mk(1'b1, IOADDR_RXTX, 8'h3C));
    pulse_rda();
    drain("rd_3c", 20);
    idle_cycles(3);
    @(negedge clk);
    check8("overrun_before", {7'd0, overrun}, 8'h00);
    spart_rd_data = 8'h96;
    pulse_rda();
    idle_cycles(2);
    @(negedge clk);
    check8("overrun_set", {7'd0, overrun}, 8'h01);
    idle_cycles(8);
    exp_q.push_back(mk(1'b0, IOADDR_RXTX, 8'h3C));
    exp_q.push_back(mk(1'b1, IOADDR_RXTX, 8'h96));
    exp_q.push_back(mk(1'b0, IOADDR_RXTX, 8'h96));
    @(posedge clk);
    #2 bus_if.tbr = 1'b1;
    drain("overrun_release", 30);
    check8("echo_96", echo_byte, 8'h96);
    check8("overrun_sticky", {7'd0, overrun}, 8'h01);

    // br_cfg change during WAIT_TBR is deferred past the echo write
    bus_if.tbr    = 1'b0;
    spart_rd_data = 8'h5A;
    exp_q.push_back(mk(1'b1, IOADDR_RXTX, 8'h5A));
    pulse_rda();
    drain("rd_5a", 20);
    @(posedge clk);
    #2 br_cfg = 2'b11;
    idle_cycles(6);
    exp_q.push_back(mk(1'b0, IOADDR_RXTX, 8'h5A));
    exp_q.push_back(mk(1'b0, IOADDR_DBLO, 8'h15));
    exp_q.push_back(mk(1'b0, IOADDR_DBHI, 8'h05));
    @(posedge clk);
    #2 bus_if.tbr = 1'b1;
    drain("cfg_38400", 30);
    idle_cycles(10);

    // Reset in the middle of a write access
    bus_if.tbr    = 1'b0;
    spart_rd_data = 8'h77;
    exp_q.push_back(mk(1'b1, IOADDR_RXTX, 8'h77));
    pulse_rda();
    drain("rd_77", 20);
    @(posedge clk);
    #2 bus_if.tbr = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    check8("wr_active_iocs", {7'd0, bus_if.iocs}, 8'h01);
    check8("wr_active_data", databus, 8'h77);
    #1 rst = 1'b1;
    #1;
    check8("abort_iocs",    {7'd0, bus_if.iocs}, 8'h00);
    check8("abort_iorw",    {7'd0, bus_if.iorw}, 8'h01);
    check8("abort_databus", databus, BG_DATA);
    bus_if.tbr = 1'b0;
    idle_cycles(3);
    @(negedge clk);
    check8("abort_echo",    echo_byte, 8'h00);
    check8("abort_overrun", {7'd0, overrun}, 8'h00);
    exp_q.push_back(mk(1'b0, IOADDR_DBLO, 8'h15));
    exp_q.push_back(mk(1'b0, IOADDR_DBHI, 8'h05));
    @(posedge clk);
    #2 rst = 1'b0;
    drain("cfg_after_rst", 20);
    idle_cycles(10);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
